sigdelay: RTL
=============

Name: sigdelay

Overview:
- Programmable audio delay line: streams input samples into a dual-port RAM and reads them back a run-time-selectable number of samples later.
- Write-side counterpart to the ROM-reading sine generator. Same counter-addressed memory structure, but this block writes the memory and reads it back.
- Sits between the sample source (mic/ADC path, or a sinegen output for loopback) and the display/DAC path.

Parameters:
- ADDRESS_WIDTH, 8, RAM address width. Depth is 2^ADDRESS_WIDTH. Maximum delay is 2^ADDRESS_WIDTH-1 samples.
- DATA_WIDTH, 8, sample width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample strobe. One sample is written and one is read per cycle with en=1.
- mic_signal  input  DATA_WIDTH  input sample, captured when en=1.
- offset  input  ADDRESS_WIDTH  delay in samples. Sampled every cycle.
- delayed_signal  output  DATA_WIDTH  delayed sample (registered).
- valid  output  1  delayed_signal holds genuinely written data for the current offset.

Behaviour:
- Interface: one clock, clk. Synchronous active-high reset, rst.
- Reset: wr_addr=0, fill_cnt=0, offset_q=0, state=FILL, delayed_signal=0, valid=0. RAM contents are not cleared.
- FSM states:
  - FILL: fewer than offset_q samples have been written since the last (re)start.
  - RUN: the delay line is primed.
- Pointers and addressing:
  - wr_addr increments by 1 mod 2^ADDRESS_WIDTH on each en=1 cycle. It wraps silently.
  - rd_addr = wr_addr - offset_q, mod 2^ADDRESS_WIDTH (unsigned wrap subtraction).
- Per en=1 cycle:
  - RAM[wr_addr] <= mic_signal.
  - The RAM read of rd_addr is registered into delayed_signal at the same edge.
  - Latency: delayed_signal after the edge ending en-cycle k equals the sample written in en-cycle k-offset_q.
- en=0: no write, no pointer or fill_cnt change, delayed_signal and valid hold.
- fill_cnt:
  - Counts en cycles since the (re)start and saturates at 2^ADDRESS_WIDTH-1.
  - valid is registered alongside the data: valid <= (fill_cnt >= offset_q), evaluated with the pre-increment fill_cnt.
  - FILL->RUN occurs on the en cycle where fill_cnt >= offset_q.
- offset change:
  - offset_q <= offset every cycle.
  - When offset != offset_q: state=FILL, fill_cnt=0, valid=0 on the next edge. wr_addr is not reset.
  - Data reads continue during FILL, but valid stays 0 until re-primed.
- offset=0 (bypass):
  - rd_addr equals wr_addr, so the RAM path is not used.
  - delayed_signal <= mic_signal (1-cycle registered pass-through). valid=1 from the first en cycle.
- Read/write collision: only possible at offset 0, which is handled by the bypass. For all other offsets rd_addr != wr_addr.
- rst mid-operation: returns to the reset values on the next edge. Stale RAM data is never flagged valid.
- Simultaneous rst and en: rst wins, and no write occurs.

Optional Feature:
- Macro: SIGDELAY_ZERO_FILL_EN.
- Defined: delayed_signal is forced to 0 whenever valid would be 0 (FILL state), so no stale or uninitialised RAM data reaches the output.
- Undefined: delayed_signal always carries the raw RAM read. Consumers must qualify it with valid.
- valid timing is identical in both builds.

Decomposition:
- Package sigdelay_pkg:
  - state enum {FILL, RUN}.
  - Default width localparams.
  - A function to compute the wrapped read address.
- Sub-module ram2port:
  - Parameters ADDRESS_WIDTH and DATA_WIDTH.
  - One synchronous write port (wr_en, wr_addr, din).
  - One synchronous read port (rd_en, rd_addr, dout), 1-cycle latency.
  - Instantiated once. The FSM, pointers and bypass mux live in sigdelay.

Test Plan:
- Reset/prime: offset=4, en=1 continuous, ramp 1,2,3,... -> valid=0 for 4 outputs. On the 5th output valid=1 and delayed_signal=1, then 2, 3, ... lock-step.
- en gating: same setup, en toggled 1010... -> outputs advance only on en=1 cycles. The delay counts en samples, not clocks. Outputs hold when en=0.
- Wrap-around: offset=255, 600-sample ramp mod 256 -> valid rises after 255 samples. delayed_signal = input from 255 samples earlier across both wr_addr wraps.
- Offset change: in RUN with offset=4, switch to offset=10 -> valid=0 on the next edge for 10 en samples, then it equals the input delayed by 10.
- Bypass: offset=0, inputs 0x55, 0xAA -> delayed_signal=0x55 then 0xAA with 1-cycle latency, valid=1 from the first sample.
- Reset mid-run / ZERO_FILL build: assert rst in RUN -> next edge delayed_signal=0, valid=0. Rerun with SIGDELAY_ZERO_FILL_EN defined -> delayed_signal=0 throughout FILL.

Source files
------------

// File: rtl/sigdelay_pkg.sv
// Shared types and helpers for the sigdelay programmable delay line.
// Optional build macro used by sigdelay: SIGDELAY_ZERO_FILL_EN.
package sigdelay_pkg;

   localparam int DEF_ADDRESS_WIDTH = 8;
   localparam int DEF_DATA_WIDTH    = 8;

   typedef enum logic {FILL, RUN} state_t;

   // Source feeding delayed_signal: reset/blanked, bypass register or RAM read.
   typedef enum logic [1:0] {SEL_ZERO, SEL_BYP, SEL_RAM} sel_t;

   // (a - b) mod 2^aw; caller truncates to its address width.
   function automatic logic [31:0] wrap_sub(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          aw);
      logic [31:0] mask;
      mask = (aw >= 32) ? '1 : ((32'd1 << aw) - 32'd1);
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/ram2port.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Contents are never cleared; read during write to the same address returns old data.
module ram2port
   import sigdelay_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    din,
   input  logic                     rd_en,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    dout
);

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDRESS_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= din;
      if (rd_en) dout <= mem[rd_addr];
   end

endmodule

// File: rtl/sigdelay.sv
// Programmable sample delay line: writes samples into a ring RAM and reads them back offset samples later.
// Build macro SIGDELAY_ZERO_FILL_EN blanks delayed_signal to 0 while valid is low.
module sigdelay
   import sigdelay_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [DATA_WIDTH-1:0]    mic_signal,
   input  logic [ADDRESS_WIDTH-1:0] offset,
   output logic [DATA_WIDTH-1:0]    delayed_signal,
   output logic                     valid
);

   logic [ADDRESS_WIDTH-1:0] wr_addr;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic [ADDRESS_WIDTH-1:0] fill_cnt;
   logic [ADDRESS_WIDTH-1:0] offset_q;
   logic [DATA_WIDTH-1:0]    byp_q;
   logic [DATA_WIDTH-1:0]    ram_dout;
   state_t                   state, state_nxt;
   sel_t                     sel_q, sel_nxt;
   logic                     valid_nxt;
   logic                     restart;
   logic                     primed;
   logic                     ram_we;

   assign rd_addr = ADDRESS_WIDTH'(wrap_sub(32'(wr_addr), 32'(offset_q), ADDRESS_WIDTH));
   assign restart = (offset != offset_q);
   assign primed  = (fill_cnt >= offset_q);
   assign ram_we  = en & ~rst;

   ram2port #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_addr (wr_addr),
      .din     (mic_signal),
      .rd_en   (ram_we),
      .rd_addr (rd_addr),
      .dout    (ram_dout)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      valid_nxt = valid;
      sel_nxt   = sel_q;
      if (restart) begin
         state_nxt = FILL;
         valid_nxt = 1'b0;
      end else if (en) begin
         valid_nxt = primed;
         case (state)
            FILL:    if (primed) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = FILL;
         endcase
      end
      // At offset 0 rd_addr == wr_addr, so the sample is taken from the bypass register.
      if (en) sel_nxt = (offset_q == '0) ? SEL_BYP : SEL_RAM;
`ifdef SIGDELAY_ZERO_FILL_EN
      if (!valid_nxt) sel_nxt = SEL_ZERO;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr  <= '0;
         fill_cnt <= '0;
         offset_q <= '0;
         byp_q    <= '0;
         sel_q    <= SEL_ZERO;
         valid    <= 1'b0;
      end else begin
         offset_q <= offset;
         sel_q    <= sel_nxt;
         valid    <= valid_nxt;
         if (restart)
            fill_cnt <= '0;
         else if (en && fill_cnt != '1)
            fill_cnt <= fill_cnt + 1'b1;
         if (en) begin
            wr_addr <= wr_addr + 1'b1;
            byp_q   <= mic_signal;
         end
      end
   end

   // Every source is a register and the select is registered, so the output is glitch-free.
   always_comb begin
      delayed_signal = '0;
      case (sel_q)
         SEL_BYP: delayed_signal = byp_q;
         SEL_RAM: delayed_signal = ram_dout;
         default: delayed_signal = '0;
      endcase
   end

endmodule
